// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the memory-mapped I/O controller.
//   - register byte offsets inside the 5-word I/O window
//   - controller state encoding
//   - decoded-register enum and the latched request bundle
package mmio_pkg;

  localparam logic [31:0] SEG_OFF      = 32'h0000_0000;
  localparam logic [31:0] LED_OFF      = 32'h0000_0004;
  localparam logic [31:0] SWT_OFF      = 32'h0000_0008;
  localparam logic [31:0] KBDATA_OFF   = 32'h0000_000C;
  localparam logic [31:0] KBSTAT_OFF   = 32'h0000_0010;
  localparam logic [31:0] WINDOW_BYTES = 32'h0000_0014;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    KB_POP
  } state_t;

  typedef enum logic [2:0] {
    REG_SEG,
    REG_LED,
    REG_SWT,
    REG_KBDATA,
    REG_KBSTAT,
    REG_NONE
  } reg_t;

  // Request captured at grant time and held for the whole transaction.
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        id;     // 0 = CPU data port, 1 = debug port
  } req_t;

  // Only SEG and LED accept writes; everything else is read-only.
  function automatic logic is_writable(input reg_t r);
    return (r == REG_SEG) || (r == REG_LED);
  endfunction

endpackage

// File: rtl/mmio_rr_arbiter.sv
// mmio_rr_arbiter: two-requester round-robin arbiter.
//   clk200m     system clock
//   rst         asynchronous active-high reset
//   req[1:0]    request level per master
//   accept      grant is taken this cycle; updates the last-grant history
//   grant_valid at least one master is requesting
//   grant_id    master selected (meaningful when grant_valid)
// On a tie the master not granted last wins; history resets to master 1 so
// master 0 wins the first tie.
module mmio_rr_arbiter (
  input  logic       clk200m,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       grant_valid,
  output logic       grant_id
);

  logic last_grant;

  always_comb begin
    grant_valid = |req;
    if (&req) grant_id = ~last_grant;
    else      grant_id = req[1];
  end

  // NOTE: clocked state is assigned with <= so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk200m or posedge rst) begin
    if (rst)                        last_grant <= 1'b1;
    else if (accept && grant_valid) last_grant <= grant_id;
  end

endmodule

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: memory-mapped I/O controller sharing the SEG/LED/SWT/keyboard
// registers between two bus masters (0 = CPU data port, 1 = debug port).
//   clk200m, rst                       clock, async active-high reset
//   mN_req/we/addr/wdata               master N request (held until ack)
//   mN_ack/err/rdata                   master N registered response
//   swt_rdata                          switch levels
//   kb_rdata, kb_ready                 keyboard FIFO head / non-empty
//   kb_rdn                             active-low one-cycle FIFO pop
//   seg_wdata, led_wdata               registered display outputs
// Each access runs IDLE -> ACCESS (WAIT_CYCLES) -> RESP -> [KB_POP] -> IDLE;
// the response registers are loaded on the edge leaving RESP.
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hA000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk200m,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  input  logic [7:0]  swt_rdata,
  input  logic [7:0]  kb_rdata,
  input  logic        kb_ready,
  output logic        kb_rdn,
  output logic [31:0] seg_wdata,
  output logic [7:0]  led_wdata
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t     state;
  req_t       txn;
  req_t       in_req;
  logic [3:0] wait_cnt;

  // Address decode: anything outside the window or not word aligned is
  // REG_NONE. Addresses below the base wrap to huge offsets and fail too.
  function automatic reg_t decode_addr(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    if (off >= WINDOW_BYTES || addr[1:0] != 2'b00) return REG_NONE;
    case (off[4:2])
      3'd0:    return REG_SEG;
      3'd1:    return REG_LED;
      3'd2:    return REG_SWT;
      3'd3:    return REG_KBDATA;
      3'd4:    return REG_KBSTAT;
      default: return REG_NONE;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Arbitration. A master whose ack is showing this cycle is still allowed to
  // hold req, so it is masked to avoid replaying the finished transaction.
  // ---------------------------------------------------------------------------
  logic [1:0] req_vec;
  logic       grant_valid;
  logic       grant_id;
  logic       accept;

  assign req_vec = {m1_req & ~m1_ack, m0_req & ~m0_ack};
  assign accept  = (state == IDLE) && grant_valid;

  mmio_rr_arbiter u_arb (
    .clk200m     (clk200m),
    .rst         (rst),
    .req         (req_vec),
    .accept      (accept),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    in_req       = '0;
    in_req.id    = grant_id;
    in_req.addr  = grant_id ? m1_addr  : m0_addr;
    in_req.we    = grant_id ? m1_we    : m0_we;
    in_req.wdata = grant_id ? m1_wdata : m0_wdata;
  end

  // ---------------------------------------------------------------------------
  // Register writes land on the edge entering RESP. With no wait states that
  // edge is the grant edge itself, so the request comes straight from the bus.
  // ---------------------------------------------------------------------------
  logic        wr_fire;
  logic [31:0] wr_addr;
  logic        wr_we;
  logic [31:0] wr_wdata;
  reg_t        wr_reg;

  always_comb begin
    wr_fire  = 1'b0;
    wr_addr  = txn.addr;
    wr_we    = txn.we;
    wr_wdata = txn.wdata;
    if (state == IDLE) begin
      wr_fire  = accept && (WAIT_CYCLES == 0);
      wr_addr  = in_req.addr;
      wr_we    = in_req.we;
      wr_wdata = in_req.wdata;
    end else if (state == ACCESS) begin
      wr_fire  = (wait_cnt == 4'd0);
    end
    wr_reg = decode_addr(wr_addr);
  end

  always_ff @(posedge clk200m or posedge rst) begin
    if (rst) begin
      seg_wdata <= '0;
      led_wdata <= '0;
    end else if (wr_fire && wr_we) begin
      if (wr_reg == REG_SEG) seg_wdata <= wr_wdata;
      if (wr_reg == REG_LED) led_wdata <= wr_wdata[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Response computed during RESP from the latched request; the keyboard
  // head and ready flag are sampled here so the pop that follows removes
  // exactly the byte that was returned.
  // ---------------------------------------------------------------------------
  reg_t        rsp_reg;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        rsp_pop;

  always_comb begin
    rsp_reg   = decode_addr(txn.addr);
    rsp_err   = (rsp_reg == REG_NONE) || (txn.we && !is_writable(rsp_reg));
    rsp_rdata = '0;
    rsp_pop   = 1'b0;
    if (!rsp_err && !txn.we) begin
      case (rsp_reg)
        REG_SEG:    rsp_rdata = seg_wdata;
        REG_LED:    rsp_rdata = {24'd0, led_wdata};
        REG_SWT:    rsp_rdata = {24'd0, swt_rdata};
        REG_KBDATA: begin
          rsp_rdata = kb_ready ? {24'd0, kb_rdata} : 32'd0;
          rsp_pop   = kb_ready;
        end
        REG_KBSTAT: rsp_rdata = {31'd0, kb_ready};
        default:    rsp_rdata = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered ack/err/rdata/kb_rdn.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk200m or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      txn      <= '0;
      wait_cnt <= '0;
      m0_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= '0;
      m1_ack   <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= '0;
      kb_rdn   <= 1'b1;
    end else begin
      m0_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= '0;
      m1_ack   <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= '0;
      kb_rdn   <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            txn <= in_req;
            if (WAIT_CYCLES > 0) begin
              wait_cnt <= WAIT_LOAD;
              state    <= ACCESS;
            end else begin
              state    <= RESP;
            end
          end
        end
        ACCESS: begin
          if (wait_cnt == 4'd0) state    <= RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        RESP: begin
          if (txn.id) begin
            m1_ack   <= 1'b1;
            m1_err   <= rsp_err;
            m1_rdata <= rsp_rdata;
          end else begin
            m0_ack   <= 1'b1;
            m0_err   <= rsp_err;
            m0_rdata <= rsp_rdata;
          end
          state <= rsp_pop ? KB_POP : IDLE;
        end
        KB_POP: begin
          kb_rdn <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
